// File: rtl/fft_waterfall_writer_if.sv
// Magnitude stream carrying one FFT frame per s_last-terminated burst.
interface fft_waterfall_writer_if #(
    parameter int unsigned MAG_WIDTH = 16
) ();
    logic                 s_valid;
    logic [MAG_WIDTH-1:0] s_data;
    logic                 s_last;
    logic                 s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fft_waterfall_writer.sv
// Quantises FFT magnitude frames into rows of a banked circular waterfall RAM,
// committing a row only when a complete, well-formed frame has been written.
module fft_waterfall_writer #(
    parameter int unsigned FFT_SIZE       = 256,
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned MAG_WIDTH      = 16,
    parameter int unsigned SHIFT          = 8,
    parameter int unsigned NO_FFTS        = 50,
    parameter int unsigned NO_BANKS       = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    fft_waterfall_writer_if.slave        s_axis,
    input  logic                         freeze,
    output logic                         we,
    output logic [NO_BANKS-1:0]          bank_wr,
    output logic [RAM_ADDR_WIDTH-1:0]    addr_wr,
    output logic [DATA_WIDTH-1:0]        data_wr,
    output logic [$clog2(NO_FFTS)-1:0]   OLDEST_FFT_IDX,
    output logic                         frame_done,
    output logic                         frame_err
);
    localparam int unsigned BIN_W         = $clog2(FFT_SIZE);
    localparam int unsigned IDX_W         = $clog2(NO_FFTS);
    localparam int unsigned HALF          = FFT_SIZE / 2;
    localparam int unsigned ROWS_PER_BANK = NO_FFTS / NO_BANKS;
    localparam int unsigned BANK_W        = (NO_BANKS > 1) ? $clog2(NO_BANKS) : 1;
    localparam int unsigned RIB_W         = (ROWS_PER_BANK > 1) ? $clog2(ROWS_PER_BANK) : 1;
    localparam logic [MAG_WIDTH-1:0] PIX_MAX = MAG_WIDTH'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {StFill, StSkip, StResync} state_e;

    state_e                    state_q, state_d;
    logic [BIN_W-1:0]          bin_q, bin_d;
    logic [IDX_W-1:0]          idx_q;
    logic [BANK_W-1:0]         bank_q;
    logic [RIB_W-1:0]          rib_q;
    logic [RAM_ADDR_WIDTH-1:0] row_base_q;

    logic                      fire;
    logic                      skip_mode;
    logic                      last_bin;
    logic                      wr_en;
    logic                      commit;
    logic                      err;
    logic [MAG_WIDTH-1:0]      shifted;
    logic [DATA_WIDTH-1:0]     pixel;

    assign s_axis.s_ready = !reset;
    assign OLDEST_FFT_IDX = idx_q;

    assign shifted = s_axis.s_data >> SHIFT;
    assign pixel   = (shifted > PIX_MAX) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        wr_en     = 1'b0;
        commit    = 1'b0;
        err       = 1'b0;
        fire      = s_axis.s_valid && s_axis.s_ready;
        last_bin  = (bin_q == BIN_W'(FFT_SIZE - 1));
        // freeze only matters on the first bin; afterwards the frame keeps its mode
        skip_mode = ((state_q != StResync) && (bin_q == '0)) ? freeze : (state_q == StSkip);

        if (fire) begin
            case (state_q)
                StResync: begin
                    bin_d = '0;
                    if (s_axis.s_last) begin
                        state_d = StFill;
                    end
                end
                default: begin
                    wr_en = !skip_mode && (bin_q < BIN_W'(HALF));
                    if (s_axis.s_last) begin
                        bin_d = '0;
                        if (last_bin) begin
                            commit  = !skip_mode;
                            state_d = StFill;
                        end else begin
                            err     = 1'b1;
                            state_d = skip_mode ? StSkip : StFill;
                        end
                    end else if (last_bin) begin
                        err     = 1'b1;
                        bin_d   = '0;
                        state_d = StResync;
                    end else begin
                        bin_d   = bin_q + 1'b1;
                        state_d = skip_mode ? StSkip : StFill;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
        end
    end

    // Row position kept as bank / row-in-bank / base address to avoid dividers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            bank_q     <= '0;
            rib_q      <= '0;
            row_base_q <= '0;
        end else if (commit) begin
            if (idx_q == IDX_W'(NO_FFTS - 1)) begin
                idx_q      <= '0;
                bank_q     <= '0;
                rib_q      <= '0;
                row_base_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
                if (rib_q == RIB_W'(ROWS_PER_BANK - 1)) begin
                    rib_q      <= '0;
                    row_base_q <= '0;
                    bank_q     <= bank_q + 1'b1;
                end else begin
                    rib_q      <= rib_q + 1'b1;
                    row_base_q <= row_base_q + RAM_ADDR_WIDTH'(HALF);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we         <= 1'b0;
            bank_wr    <= '0;
            addr_wr    <= '0;
            data_wr    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            we         <= wr_en;
            frame_done <= commit;
            frame_err  <= err;
            if (wr_en) begin
                bank_wr <= NO_BANKS'(1) << bank_q;
                addr_wr <= row_base_q + RAM_ADDR_WIDTH'(bin_q);
                data_wr <= pixel;
            end
        end
    end
endmodule
